// File: rtl/qspi_bus_bridge_pkg.sv
// Shared definitions for the QSPI byte-command bridge.
//   state_e       : bridge FSM states
//   CMD_WRITE_BIT : command bit selecting write (1) or read (0)
//   ADDR_BYTES    : number of wire address bytes, MSB first
//   OPCODE_MEM    : cmd[7:1] value that selects a memory access
package qspi_bus_bridge_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StWdata,
      StWbus,
      StRreq,
      StRbus,
      StIgnore
   } state_e;

   localparam int unsigned CMD_WRITE_BIT = 0;
   localparam int unsigned ADDR_BYTES    = 3;
   localparam logic [6:0]  OPCODE_MEM    = 7'h00;

endpackage

// File: rtl/qspi_bus_bridge_if.sv
// Signal bundle between the QSPI front-end / memory bus and the bridge.
//   start               : new-transaction pulse from the front-end
//   rx_data/valid/ready : RX FIFO byte stream into the bridge
//   tx_data/push/space  : TX FIFO byte stream out of the bridge
//   bus_*               : single-outstanding byte memory bus driven by the bridge
// Modports: master = bridge side, slave = front-end / memory side.
interface qspi_bus_bridge_if #(
   parameter int unsigned ADDR_W = 24
);

   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [7:0]        tx_data;
   logic              tx_push;
   logic              tx_space;
   logic [ADDR_W-1:0] bus_addr;
   logic [7:0]        bus_wdata;
   logic              bus_wr;
   logic              bus_rd;
   logic              bus_ack;
   logic [7:0]        bus_rdata;

   modport master (
      input  start, rx_data, rx_valid, tx_space, bus_ack, bus_rdata,
      output rx_ready, tx_data, tx_push, bus_addr, bus_wdata, bus_wr, bus_rd
   );

   modport slave (
      output start, rx_data, rx_valid, tx_space, bus_ack, bus_rdata,
      input  rx_ready, tx_data, tx_push, bus_addr, bus_wdata, bus_wr, bus_rd
   );

endinterface

// File: rtl/qspi_bus_bridge.sv
// Byte-level command parser behind the QSPI slave front-end. Parses cmd + 3 address bytes, then
// streams byte writes (one per RX data byte) or prefetching byte reads (pushed to the TX FIFO)
// on a single-outstanding memory bus, auto-incrementing the address.
// Ports:
//   qspi_clk   : clock
//   qspi_reset : synchronous active-high reset
//   bus        : qspi_bus_bridge_if.master (start, RX, TX and memory bus signals)
module qspi_bus_bridge
   import qspi_bus_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 24,
   parameter logic [6:0]  OPCODE = OPCODE_MEM
) (
   input logic               qspi_clk,
   input logic               qspi_reset,
   qspi_bus_bridge_if.master bus
);

   // Keeps the auto-increment modulo 2^ADDR_W on the 24-bit wire address.
   localparam logic [23:0] AddrMask = 24'((64'd1 << ADDR_W) - 64'd1);

   state_e      state_q, state_d;
   logic [23:0] addr_q, addr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic        write_q, write_d;
   logic [7:0]  wdata_q, wdata_d;

   logic        pop;
   logic        rd_req;
   logic        wr_req;
   logic        push;
   logic        ack_done;
   logic [23:0] addr_inc;

   assign addr_inc = (addr_q + 24'd1) & AddrMask;
   assign ack_done = (rd_req | wr_req) & bus.bus_ack;

   always_ff @(posedge qspi_clk) begin
      if (qspi_reset) begin
         state_q <= StIdle;
         addr_q  <= 24'h0;
         cnt_q   <= 2'd0;
         pend_q  <= 1'b0;
         write_q <= 1'b0;
         wdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      write_d = write_q;
      wdata_d = wdata_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) state_d = StCmd;
         end
         StCmd: begin
            if (bus.start) begin
               state_d = StCmd;
            end else if (pop) begin
               cnt_d   = 2'd0;
               write_d = bus.rx_data[CMD_WRITE_BIT];
               state_d = (bus.rx_data[7:1] == OPCODE) ? StAddr : StIgnore;
            end
         end
         StAddr: begin
            if (bus.start) begin
               state_d = StCmd;
            end else if (pop) begin
               addr_d = {addr_q[15:0], bus.rx_data};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'(ADDR_BYTES - 1)) state_d = write_q ? StWdata : StRreq;
            end
         end
         StWdata: begin
            if (bus.start) begin
               state_d = StCmd;
            end else if (pop) begin
               wdata_d = bus.rx_data;
               state_d = StWbus;
            end
         end
         StRreq: begin
            if (bus.start) begin
               state_d = StCmd;
            end else if (ack_done) begin
               addr_d = addr_inc;
            end else if (rd_req) begin
               state_d = StRbus;
            end
         end
         StWbus, StRbus: begin
            // The bus cannot abort, so a start here is parked until the ack.
            if (bus.bus_ack) begin
               pend_d = 1'b0;
               if (pend_q || bus.start) begin
                  state_d = StCmd;
               end else begin
                  addr_d  = addr_inc;
                  state_d = (state_q == StWbus) ? StWdata : StRreq;
               end
            end else if (bus.start) begin
               pend_d = 1'b1;
            end
         end
         StIgnore: begin
            if (bus.start) state_d = StCmd;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pop    = 1'b0;
      rd_req = 1'b0;
      wr_req = 1'b0;
      push   = 1'b0;
      unique case (state_q)
         StCmd, StAddr, StWdata, StIgnore: pop = bus.rx_valid & ~bus.start;
         StWbus: wr_req = 1'b1;
         StRreq: begin
            // Issue in the cycle after the last address byte; a start cancels before issue.
            rd_req = bus.tx_space & ~bus.start;
            push   = rd_req & bus.bus_ack;
         end
         StRbus: begin
            rd_req = 1'b1;
            push   = bus.bus_ack & bus.tx_space & ~pend_q & ~bus.start;
         end
         default: ;
      endcase
   end

   assign bus.rx_ready  = pop;
   assign bus.tx_push   = push;
   assign bus.tx_data   = push ? bus.bus_rdata : 8'h00;
   assign bus.bus_addr  = addr_q[ADDR_W-1:0];
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_wr    = wr_req;
   assign bus.bus_rd    = rd_req;

endmodule
